// File: rtl/map_ctrl.sv
// map_ctrl: owns the 15x10 tile map; loads a level from a synchronous ROM, then arbitrates tile-clear requests.
// Define MAP_CTRL_VBLANK_COMMIT_EN to restrict grants to vertical-blank cycles (default: grant in any RUN cycle).
module map_ctrl #(
  parameter int LEVELS = 4,
  parameter int ROM_AW = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_level_sel,
  input  logic              i_vblnk_in,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [3:0]        i_rom_data,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic [7:0]        i_idx0,
  input  logic [7:0]        i_idx1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic              o_hit,
  output logic              o_powerup_evt,
  output logic [599:0]      o_map,
  output logic [7:0]        o_coins_left,
  output logic              o_busy,
  output logic              o_level_clear
);
  localparam int NT = 150;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_CLEAR} state_t;

  state_t            r_state;
  logic [3:0]        r_tile [NT];
  logic [7:0]        r_coins;
  logic [7:0]        r_cnt;
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_busy;
  logic              r_level_clear;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_hit;
  logic              r_pwr;
  logic              r_ptr;

  logic              w_accept;
  logic              w_grant_ok;
  logic              w_r0;
  logic              w_r1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic [7:0]        w_gidx;
  logic [7:0]        w_wr_idx;
  logic [3:0]        w_gtype;
  logic [ROM_AW-1:0] w_base;
  logic              w_unused_cfg;

  assign w_unused_cfg = ((LEVELS * NT) <= (1 << ROM_AW));
  assign w_accept     = i_start && (r_state != S_LOAD);
  assign w_base       = ROM_AW'(i_level_sel) * ROM_AW'(NT);
  assign w_wr_idx     = r_cnt - 8'd1;

`ifdef MAP_CTRL_VBLANK_COMMIT_EN
  assign w_grant_ok = (r_state == S_RUN) && (r_coins != 8'd0) && i_vblnk_in;
`else
  logic w_unused_vblnk;
  assign w_unused_vblnk = i_vblnk_in;
  assign w_grant_ok     = (r_state == S_RUN) && (r_coins != 8'd0);
`endif

  // A requester whose ack is on the bus this cycle is still showing the old request.
  assign w_r0    = i_req0 && !r_ack0;
  assign w_r1    = i_req1 && !r_ack1;
  assign w_gnt0  = w_grant_ok && w_r0 && (!w_r1 || !r_ptr);
  assign w_gnt1  = w_grant_ok && w_r1 && (!w_r0 || r_ptr);
  assign w_gidx  = w_gnt1 ? i_idx1 : i_idx0;
  assign w_gtype = (w_gidx < 8'd150) ? r_tile[w_gidx] : 4'd0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      for (int i = 0; i < NT; i++) r_tile[i] <= 4'd0;
      r_coins       <= 8'd0;
      r_cnt         <= 8'd0;
      r_rom_addr    <= '0;
      r_busy        <= 1'b0;
      r_level_clear <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_hit         <= 1'b0;
      r_pwr         <= 1'b0;
      r_ptr         <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_hit  <= 1'b0;
      r_pwr  <= 1'b0;
      if (w_accept) begin
        r_state       <= S_LOAD;
        for (int i = 0; i < NT; i++) r_tile[i] <= 4'd0;
        r_coins       <= 8'd0;
        r_cnt         <= 8'd0;
        r_rom_addr    <= w_base;
        r_busy        <= 1'b1;
        r_level_clear <= 1'b0;
      end else begin
        case (r_state)
          // ROM data lags the address by one cycle, so tile cnt-1 is written while cnt advances.
          S_LOAD: begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt < 8'd149) r_rom_addr <= r_rom_addr + 1'b1;
            if (r_cnt != 8'd0) begin
              r_tile[w_wr_idx] <= i_rom_data;
              if (i_rom_data == 4'd2) r_coins <= r_coins + 8'd1;
            end
            if (r_cnt == 8'd150) begin
              r_state <= S_RUN;
              r_busy  <= 1'b0;
            end
          end
          S_RUN: begin
            if (r_coins == 8'd0) begin
              r_state       <= S_CLEAR;
              r_level_clear <= 1'b1;
            end else if (w_gnt0 || w_gnt1) begin
              r_ack0 <= w_gnt0;
              r_ack1 <= w_gnt1;
              r_ptr  <= w_gnt0;
              if (w_gtype == 4'd2 || w_gtype == 4'd3) begin
                r_tile[w_gidx] <= 4'd0;
                r_hit          <= 1'b1;
              end
              if (w_gtype == 4'd2) r_coins <= r_coins - 8'd1;
              if (w_gtype == 4'd3) r_pwr   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_map = '0;
    for (int i = 0; i < NT; i++) o_map[4*i +: 4] = r_tile[i];
  end

  assign o_rom_addr    = r_rom_addr;
  assign o_coins_left  = r_coins;
  assign o_busy        = r_busy;
  assign o_level_clear = r_level_clear;
  assign o_ack0        = r_ack0;
  assign o_ack1        = r_ack1;
  assign o_hit         = r_hit;
  assign o_powerup_evt = r_pwr;
endmodule

// File: tb/tb_map_ctrl.sv
// tb_map_ctrl: directed bench for map_ctrl with a behavioural level ROM and an ack scoreboard.
module tb_map_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   lsel = 2'd0;
  logic         vblnk = 1'b0;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [7:0]   idx0 = 8'd0;
  logic [7:0]   idx1 = 8'd0;
  logic [3:0]   rom_data;
  logic [9:0]   rom_addr;
  logic         ack0, ack1, hit, pwr, busy, lc;
  logic [599:0] map;
  logic [7:0]   coins;

  int total = 0;
  int bad = 0;

  logic [3:0] rom [1024];
  logic [3:0] mdl [150];
  logic [7:0] mdl_coins;

  typedef struct packed {logic who; logic hit; logic pwr;} exp_t;
  exp_t       sb[$];
  exp_t       mon_e;
  logic [9:0] addr_q[$];

  map_ctrl #(.LEVELS(4), .ROM_AW(10)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_level_sel(lsel), .i_vblnk_in(vblnk),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .i_req0(req0), .i_req1(req1), .i_idx0(idx0), .i_idx1(idx1),
    .o_ack0(ack0), .o_ack1(ack1), .o_hit(hit), .o_powerup_evt(pwr),
    .o_map(map), .o_coins_left(coins), .o_busy(busy), .o_level_clear(lc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [599:0] got, input logic [599:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [599:0] pack_mdl();
    logic [599:0] v;
    v = '0;
    for (int i = 0; i < 150; i++) v[4*i +: 4] = mdl[i];
    return v;
  endfunction

  // Scoreboard: every ack pops the expectation pushed when the request was driven.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (ack0 === 1'b1 || ack1 === 1'b1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 600'({ack1, ack0}), 600'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("ack_who", 600'({ack1, ack0}), 600'({mon_e.who, ~mon_e.who}));
        chk("hit", 600'(hit), 600'(mon_e.hit));
        chk("powerup_evt", 600'(pwr), 600'(mon_e.pwr));
      end
    end
  end

  task automatic load_level(input logic [1:0] lv, input bit poke);
    int n;
    for (int k = 0; k < 150; k++) addr_q.push_back(10'(int'(lv) * 150 + k));
    addr_q.push_back(10'(int'(lv) * 150 + 149));
    mdl_coins = 8'd0;
    for (int k = 0; k < 150; k++) begin
      mdl[k] = rom[int'(lv) * 150 + k];
      if (mdl[k] == 4'd2) mdl_coins = mdl_coins + 8'd1;
    end
    start = 1'b1;
    lsel  = lv;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      if (addr_q.size() != 0) chk("rom_addr", 600'(rom_addr), 600'(addr_q.pop_front()));
      else chk("rom_addr_overrun", 600'(n), 600'(150));
      if (poke && n == 30) begin
        start = 1'b1;
        lsel  = 2'd2;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", 600'(n), 600'(151));
    chk("addr_q_drained", 600'(addr_q.size()), 600'(0));
    chk("load_map", map, pack_mdl());
    chk("load_coins", 600'(coins), 600'(mdl_coins));
  endtask

  task automatic req_one(input bit who, input logic [7:0] idx);
    logic [3:0] t;
    exp_t       e;
    int         n;
    t = (idx < 8'd150) ? mdl[idx] : 4'd0;
    e.who = who;
    e.hit = (t == 4'd2 || t == 4'd3);
    e.pwr = (t == 4'd3);
    sb.push_back(e);
    if (e.hit) begin
      mdl[idx] = 4'd0;
      if (t == 4'd2) mdl_coins = mdl_coins - 8'd1;
    end
    if (who) begin req1 = 1'b1; idx1 = idx; end
    else     begin req0 = 1'b1; idx0 = idx; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((who ? ack1 : ack0) === 1'b1) && n < 20);
    if (who) req1 = 1'b0; else req0 = 1'b0;
    chk("ack_latency", 600'(n), 600'(1));
    chk("map_after_ack", map, pack_mdl());
    chk("coins_after_ack", 600'(coins), 600'(mdl_coins));
    @(negedge clk);
    chk("evt_pulse_end", 600'({pwr, hit, ack1, ack0}), 600'(0));
  endtask

  initial begin
    int n, n0, n1;
    exp_t e;
    for (int i = 0; i < 1024; i++) rom[i] = 4'd0;
    rom[0] = 4'd1;  rom[5] = 4'd9;  rom[20] = 4'd3;  rom[149] = 4'd15;
    rom[150] = 4'd1; rom[153] = 4'd1; rom[154] = 4'd1;
    rom[157] = 4'd2; rom[170] = 4'd2; rom[190] = 4'd2; rom[210] = 4'd2; rom[299] = 4'd2;
    rom[160] = 4'd3; rom[161] = 4'd12;
    for (int i = 300; i < 450; i++) rom[i] = 4'd2;
`ifdef MAP_CTRL_VBLANK_COMMIT_EN
    vblnk = 1'b1;
`else
    vblnk = 1'b0;
`endif

    repeat (2) @(negedge clk);
    chk("rst_map", map, 600'(0));
    chk("rst_ctrl", 600'({rom_addr, coins, busy, lc, ack0, ack1, hit, pwr}), 600'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a load.
    start = 1'b1; lsel = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("midload_busy", 600'(busy), 600'(1));
    rst_n = 1'b0;
    #1;
    chk("midload_rst_map", map, 600'(0));
    chk("midload_rst_ctrl", 600'({rom_addr, coins, busy, lc, ack0, ack1, hit, pwr}), 600'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    load_level(2'd1, 1'b1);
    chk("lc_after_load1", 600'(lc), 600'(0));

    req_one(1'b0, 8'd7);
    req_one(1'b1, 8'd200);

    for (int k = 0; k < 4; k++) begin
      e.who = k[0]; e.hit = 1'b0; e.pwr = 1'b0;
      sb.push_back(e);
    end
    req0 = 1'b1; idx0 = 8'd3; req1 = 1'b1; idx1 = 8'd4;
    n = 0; n0 = 0; n1 = 0;
    while ((req0 || req1) && n < 20) begin
      @(negedge clk);
      n++;
      if (ack0 === 1'b1) begin n0++; if (n0 == 2) req0 = 1'b0; end
      if (ack1 === 1'b1) begin n1++; if (n1 == 2) req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("both_acks_all_seen", 600'(sb.size()), 600'(0));
    chk("both_map_unchanged", map, pack_mdl());

    req_one(1'b0, 8'd3);
    req_one(1'b1, 8'd10);

`ifdef MAP_CTRL_VBLANK_COMMIT_EN
    vblnk = 1'b0;
    e.who = 1'b0; e.hit = 1'b1; e.pwr = 1'b0;
    sb.push_back(e);
    mdl[20] = 4'd0; mdl_coins = mdl_coins - 8'd1;
    req0 = 1'b1; idx0 = 8'd20;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack0 === 1'b1) n++;
    end
    chk("vblank_hold", 600'(n), 600'(0));
    vblnk = 1'b1;
    @(negedge clk);
    chk("vblank_ack", 600'(ack0), 600'(1));
    req0 = 1'b0;
    @(negedge clk);
    chk("vblank_map", map, pack_mdl());
`else
    req_one(1'b0, 8'd20);
`endif

    req_one(1'b0, 8'd40);
    req_one(1'b1, 8'd60);
    chk("lc_before_last", 600'(lc), 600'(0));
    req_one(1'b0, 8'd149);
    chk("lc_after_last", 600'(lc), 600'(1));

    // Requests in CLEAR stay pending and are never acked.
    req1 = 1'b1; idx1 = 8'd3;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack1 === 1'b1) n++;
    end
    req1 = 1'b0;
    chk("clear_no_ack", 600'(n), 600'(0));
    chk("clear_map_frozen", map, pack_mdl());

    load_level(2'd0, 1'b0);
    chk("lc_run_nocoin", 600'(lc), 600'(0));
    @(negedge clk);
    chk("lc_nocoin_level", 600'(lc), 600'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/map_ctrl.md
# map_ctrl

Owns the 15×10 tile map (150 tiles × 4 bit) consumed by the renderer/collision stage as a flat 600-bit bus. Loads a level from a synchronous level ROM, then arbitrates tile-clear (pickup) requests from the two player-logic blocks with a round-robin arbiter. Tracks remaining coins and flags level completion. Sits between the level ROM, the two hero controllers and the draw stage.

## Interface
- `LEVELS`, 4 — number of levels stored in ROM.
- `ROM_AW`, 10 — ROM address width; must satisfy `LEVELS*150 <= 2**ROM_AW`.
- `clk` in 1 — pixel-domain clock.
- `rst` in 1 — asynchronous, active-low reset (asserted at 0).
- `start` in 1 — level load request, sampled each cycle.
- `level_sel` in 2 — level index, latched when `start` is accepted.
- `vblnk_in` in 1 — vertical blanking from timing chain.
- `rom_addr` out ROM_AW — level ROM address, registered.
- `rom_data` in 4 — ROM tile type, valid one cycle after `rom_addr`.
- `req0`, `req1` in 1 — pickup request, player 0/1; held until matching ack.
- `idx0`, `idx1` in 8 — tile index (x + 15·y), stable while req high.
- `ack0`, `ack1` out 1 — one-cycle grant pulse.
- `hit` out 1 — valid with an ack pulse: 1 if the tile was COIN/POWERUP and was cleared.
- `powerup_evt` out 1 — one-cycle pulse when a POWERUP tile is cleared.
- `map` out 600 — tile i in bits [4i+3:4i]; 0 BLANK, 1 WALL, 2 COIN, 3 POWERUP.
- `coins_left` out 8 — COIN tiles remaining.
- `busy` out 1 — high while loading.
- `level_clear` out 1 — high in CLEAR state.

## Operation
- States: IDLE, LOAD, RUN, CLEAR.
- IDLE: waits for `start`. `start` accepted in IDLE, RUN, CLEAR; ignored in LOAD.
- On accept: latch `level_sel`; zero all 150 tiles and `coins_left`; enter LOAD; `rom_addr` = `level_sel`·150.
- LOAD: `rom_addr` steps base+0 … base+149, one per cycle; each `rom_data` written to the tile addressed on the previous cycle; `coins_left` incremented for every COIN. After tile 149 is written → RUN. `rom_data` values 4–15 stored as-is, not counted.
- RUN: at most one grant per cycle. One requester → granted. Both → the one not granted last; after reset, player 0 has priority. Pointer updates only on a grant.
- On grant: idx ≥ 150 or type BLANK/WALL → ack, `hit`=0, no change. COIN → tile := BLANK, `coins_left`−1, `hit`=1. POWERUP → tile := BLANK, `hit`=1, `powerup_evt`=1.
- Requests pending in IDLE, LOAD or CLEAR are not acked; they remain pending.
- RUN with `coins_left`=0 (including right after a load with no coins) → CLEAR next cycle. CLEAR holds `level_clear`=1 and `map` frozen until the next `start`.
- Reset values: state IDLE, `map` all 0, `coins_left` 0, `rom_addr` 0, `busy` 0, `level_clear` 0, `ack0/1` 0, `hit` 0, `powerup_evt` 0, arbiter pointer → player 0.

## Timing
- `start` sampled at edge N → `busy`=1 and `rom_addr`=base from N+1; tiles written N+2 … N+151; `busy`=0 and state RUN from N+152.
- Grant decision uses the registered `map`. Ack, `hit`, `powerup_evt`, tile update and `coins_left` update all appear one cycle after the grant cycle.
- A requester must drop `req` the cycle after its ack; if it is still high, that is a new request.
- `map` is a register output, so the draw stage sees a change one cycle after the ack edge.

## Configuration
- `MAP_CTRL_VBLANK_COMMIT_EN` defined: grants in RUN are issued only in cycles with `vblnk_in`=1; requests wait across the active frame, so there is no mid-frame tearing.
- Undefined: `vblnk_in` is ignored and grants are issued in any RUN cycle.

## Test plan
- Reset low mid-LOAD → all outputs return to their reset values immediately. `start`, `level_sel`=1 with level 1 holding 5 COIN tiles → `busy` high exactly 151 cycles, `rom_addr` 150…299, `coins_left`=5, `map` matches ROM.
- `req0`, `idx0`=7 on a COIN tile → `ack0`, `hit`=1, tile 7 = 0, `coins_left` 5→4.
- `req0` and `req1` held together for 4 grants → ack order 0,1,0,1; a single WALL request → ack, `hit`=0, map unchanged.
- `idx1`=200 → `ack1`, `hit`=0; POWERUP tile → `hit`=1, one `powerup_evt` pulse.
- Clear the last coin → `level_clear`=1 the following cycle and further requests not acked; `start` during LOAD → load not restarted.
- With `MAP_CTRL_VBLANK_COMMIT_EN`: request while `vblnk_in`=0 → no ack until the first `vblnk_in`=1 cycle.
